// File: rtl/bus_width_increase_if.sv
// Narrow-in / wide-out valid-ready stream bundle for the bus width increaser.
interface bus_width_increase_if #(
  parameter int SIZE_IN  = 8,
  parameter int SIZE_OUT = 32
);
  logic                         input_ready;
  logic                         input_valid;
  logic [SIZE_IN-1:0]           data_in;
  logic                         input_last;
  logic                         output_ready;
  logic                         output_valid;
  logic [SIZE_OUT-1:0]          data_out;
  logic [SIZE_OUT/SIZE_IN-1:0]  output_keep;
  logic                         output_last;

  modport slave (
    output input_ready, output_valid, data_out, output_keep, output_last,
    input  input_valid, data_in, input_last, output_ready
  );

  modport master (
    input  input_ready, output_valid, data_out, output_keep, output_last,
    output input_valid, data_in, input_last, output_ready
  );
endinterface

// File: rtl/bus_width_increase.sv
// Packs narrow beats into wide words; accumulator plus output register give
// one beat per cycle while a finished word waits for the consumer.
module bus_width_increase #(
  parameter int SIZE_IN       = 8,
  parameter int SIZE_OUT      = 32,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  bus_width_increase_if.slave bus
);
  localparam int BEATS = SIZE_OUT / SIZE_IN;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if ((SIZE_OUT % SIZE_IN) != 0 || SIZE_OUT < 2 * SIZE_IN) begin : g_size_check
    $error("bus_width_increase: SIZE_OUT must be a multiple of SIZE_IN and >= 2*SIZE_IN");
  end

  logic [SIZE_OUT-1:0] acc_data;
  logic [SIZE_OUT-1:0] ins_data;
  logic [BEATS-1:0]    acc_keep;
  logic [BEATS-1:0]    ins_keep;
  logic [CW-1:0]       count;
  logic                acc_full;
  logic                acc_last;
  logic                accept;
  logic                drain;
  logic                complete;
  logic                out_free;
  logic                hold_acc;

  assign accept   = bus.input_valid && bus.input_ready;
  assign drain    = bus.output_valid && bus.output_ready;
  assign out_free = !bus.output_valid || bus.output_ready;
  assign complete = accept && (bus.input_last || (count == CW'(BEATS - 1)));
  // A completed word parks in the accumulator only if the output register can't take it.
  assign hold_acc = acc_full ? !drain : (complete && !out_free);

  always_comb begin
    ins_data = acc_data;
    ins_keep = acc_keep;
    for (int i = 0; i < BEATS; i++) begin
      if (count == CW'(i)) begin
        if (LITTLE_ENDIAN)
          ins_data[i*SIZE_IN +: SIZE_IN] = bus.data_in;
        else
          ins_data[(BEATS-1-i)*SIZE_IN +: SIZE_IN] = bus.data_in;
        ins_keep[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_data         <= '0;
      acc_keep         <= '0;
      acc_last         <= 1'b0;
      acc_full         <= 1'b0;
      count            <= '0;
      bus.input_ready  <= 1'b0;
      bus.output_valid <= 1'b0;
      bus.data_out     <= '0;
      bus.output_keep  <= '0;
      bus.output_last  <= 1'b0;
    end else begin
      acc_full        <= hold_acc;
      bus.input_ready <= !hold_acc;
      if (drain)
        bus.output_valid <= 1'b0;

      if (acc_full && drain) begin
        bus.output_valid <= 1'b1;
        bus.data_out     <= acc_data;
        bus.output_keep  <= acc_keep;
        bus.output_last  <= acc_last;
        acc_data         <= '0;
        acc_keep         <= '0;
        acc_last         <= 1'b0;
      end else if (accept) begin
        if (complete && out_free) begin
          bus.output_valid <= 1'b1;
          bus.data_out     <= ins_data;
          bus.output_keep  <= ins_keep;
          bus.output_last  <= bus.input_last;
          acc_data         <= '0;
          acc_keep         <= '0;
          count            <= '0;
        end else if (complete) begin
          acc_data <= ins_data;
          acc_keep <= ins_keep;
          acc_last <= bus.input_last;
          count    <= '0;
        end else begin
          acc_data <= ins_data;
          acc_keep <= ins_keep;
          count    <= count + CW'(1);
        end
      end
    end
  end
endmodule

// File: doc/bus_width_increase.md
Name: bus_width_increase

Overview:
- Gathers beats from a narrow valid/ready stream and emits them as one wide word on a wider valid/ready stream. It is the receive-side counterpart to the wide-to-narrow serializer.
- It sits at the inbound edge of wide datapaths, e.g. UART/byte streams feeding 32-bit buffers.
- It has two storage stages: an accumulator plus an output register. A full word can wait on the output while the next one accumulates, so sustained throughput is one input beat per cycle.
- A last flag flushes a partial word and marks the valid lanes with a keep mask.

Parameters:
SIZE_IN, 8, narrow input width in bits
SIZE_OUT, 32, wide output width in bits; must be an integer multiple of SIZE_IN and at least 2*SIZE_IN (elaboration-time assert with $error)
LITTLE_ENDIAN, 1, 1: first beat lands in data_out[SIZE_IN-1:0]; 0: first beat lands in data_out[SIZE_OUT-1 -: SIZE_IN]

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
input_ready  output  1  block can accept a narrow beat this cycle
input_valid  input  1  data_in/input_last valid
data_in  input  SIZE_IN  narrow beat
input_last  input  1  beat ends the word early (flush partial word)
output_ready  input  1  downstream accepts data_out this cycle
output_valid  output  1  data_out/output_keep/output_last valid
data_out  output  SIZE_OUT  assembled wide word
output_keep  output  SIZE_OUT/SIZE_IN  one bit per lane, 1 = lane holds a received beat
output_last  output  1  word was closed by input_last

Behaviour:
- BEATS = SIZE_OUT/SIZE_IN. The lane counter is $clog2(BEATS) bits wide and is compared against BEATS-1 explicitly, so BEATS need not be a power of two.
- Reset (rst_n low at a clock edge) forces the following, regardless of in-flight data:
  - output_valid=0, output_last=0, output_keep=0, data_out=0.
  - Accumulator cleared, lane counter=0, acc_full=0.
  - input_ready=0 during reset; it is 1 in the first cycle after rst_n is sampled high.
  - A partial word present at reset is discarded.
- Transfers occur only on valid&&ready at a clock edge. input_ready is registered: input_ready = rst_n_q && !acc_full.
- Beat accept:
  - data_in is written into lane[count] of the accumulator and keep[count] is set. Lane i = bits [i*SIZE_IN +: SIZE_IN] when LITTLE_ENDIAN, else lane i = bits [(BEATS-1-i)*SIZE_IN +: SIZE_IN].
  - count increments.
- Word complete when an accepted beat has count==BEATS-1 or input_last=1.
  - If the output register is empty, or is being drained this cycle (output_valid && output_ready): the completed word goes straight to the output register, including this beat, its keep mask and output_last=input_last. The accumulator and count clear and input_ready stays 1. Latency: output_valid is high the cycle after the completing beat is accepted.
  - Otherwise: the completed word is held in the accumulator, acc_full=1, and input_ready=0 next cycle.
- acc_full && output_valid && output_ready: the accumulator moves into the output register; acc_full=0 and input_ready=1 next cycle. output_valid stays 1, so back-to-back words have no bubble on the output.
- Output drained (output_valid && output_ready) with no word completing and !acc_full: output_valid=0 next cycle.
- Unfilled lanes of a flushed word read as 0 with keep=0. A full word has keep all-ones.
- output_valid, data_out, output_keep and output_last hold stable while output_valid && !output_ready.
- input_last on the very first beat produces a one-lane word (keep=...0001 in lane order).
- input_valid low mid-word: the partial word waits indefinitely with no timeout.
- Counter wrap: after the BEATS-th beat the count returns to 0.

Test Plan:
- SIZE_IN=8, SIZE_OUT=32, LE=1, output_ready=1; send 0x11,0x22,0x33,0x44 on consecutive cycles -> the cycle after the 4th accept: output_valid=1, data_out=0x44332211, keep=4'b1111, last=0; input_ready stays 1 throughout.
- Same beats with LITTLE_ENDIAN=0 -> data_out=0x11223344.
- Send 0xAA, then 0xBB with input_last=1 -> data_out=0x0000BBAA, keep=4'b0011, output_last=1; the next word starts at lane 0.
- output_ready=0 while streaming 12 beats 0x01..0x0C:
  - word0 0x04030201 sits in the output register;
  - word1 fills the accumulator and input_ready drops after the 8th accept; beats 9-12 are stalled.
  - Then raise output_ready: word0 and word1 appear on consecutive cycles; input_ready returns and word2=0x0C0B0A09 follows.
- Sustained 1 beat/cycle with output_ready toggling 1,0,1,0 -> no dropped or duplicated beats; a scoreboard matches 16 words in order.
- Reset mid-operation: assert rst_n=0 after 2 beats with a word pending on the output -> next cycle output_valid=0, keep=0; after release, 4 new beats yield only the new word.
